// File: rtl/clkdiv_prog_if.sv
// Divisor-change handshake between a requester (software/DVFS) and clkdiv_prog.
interface clkdiv_prog_if #(
    parameter int unsigned DIV_W = 4
);
    logic             div_req;
    logic [DIV_W-1:0] div_val;
    logic             div_busy;
    logic             div_ack;
    logic             div_err;
    logic [DIV_W-1:0] cur_div;

    modport master (
        output div_req, div_val,
        input  div_busy, div_ack, div_err, cur_div
    );

    modport slave (
        input  div_req, div_val,
        output div_busy, div_ack, div_err, cur_div
    );
endinterface

// File: rtl/clkdiv_prog.sv
// Run-time programmable integer clock divider with glitch-free divisor handshake.
// Define CLKDIV_PROG_ODD50_EN to add the negedge phase flop for 50% duty on odd divisors.
module clkdiv_prog #(
    parameter int unsigned DIV_W     = 4,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic           clkin,
    input  logic           rstn,
    clkdiv_prog_if.slave   bus,
    output logic           tick,
    output logic           clk_out
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RESET);
    localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DIV_RESET - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_q, cur_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pos_hi_q, pos_hi_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
    logic             boundary_c;
    logic             byp_en;
    logic             neg_hi;

    assign boundary_c = (cnt_q == cur_q - DIV_W'(1));

    // Period counter, handshake FSM and phase flop next-state
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tick_d  = boundary_c;
        cnt_d   = boundary_c ? '0 : cnt_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.div_req) begin
                    if (bus.div_val == '0) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = bus.div_val;
                        busy_d  = 1'b1;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (boundary_c) begin
                    cur_d   = pend_q;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        // cnt_d is 0 on a boundary, so a new divisor takes effect from its first cycle
        pos_hi_d = (cnt_d < (cur_d >> 1));
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= RST_CNT;
            cur_q    <= RST_DIV;
            pend_q   <= RST_DIV;
            pos_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            pos_hi_q <= pos_hi_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            tick_q   <= tick_d;
        end
    end

    // Bypass enable changes only while clkin is low, so N=1 entry/exit cannot glitch
    always_ff @(negedge clkin or negedge rstn) begin
        if (!rstn) begin
            byp_en <= 1'b0;
        end else begin
            byp_en <= (cur_q == DIV_W'(1));
        end
    end

`ifdef CLKDIV_PROG_ODD50_EN
    // Stretches the high phase by half a cycle for odd divisors only
    always_ff @(negedge clkin or negedge rstn) begin
        if (!rstn) begin
            neg_hi <= 1'b0;
        end else begin
            neg_hi <= pos_hi_q & cur_q[0];
        end
    end
`else
    assign neg_hi = 1'b0;
`endif

    assign clk_out      = pos_hi_q | neg_hi | (clkin & byp_en);
    assign tick         = tick_q;
    assign bus.div_busy = busy_q;
    assign bus.div_ack  = ack_q;
    assign bus.div_err  = err_q;
    assign bus.cur_div  = cur_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Randomized bench for clkdiv_prog against a period-level reference model.
module tb_clkdiv_prog;

    localparam int unsigned DIV_W     = 4;
    localparam int unsigned DIV_RESET = 2;
`ifdef CLKDIV_PROG_ODD50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic clkin;
    logic rstn;
    logic tick;
    logic clk_out;

    clkdiv_prog_if #(.DIV_W(DIV_W)) bus ();

    clkdiv_prog #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) dut (
        .clkin   (clkin),
        .rstn    (rstn),
        .bus     (bus),
        .tick    (tick),
        .clk_out (clk_out)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the divider as a sequence of periods of length m_n
    int m_n, m_left, m_ph, m_pend;
    bit m_busy, m_fresh, m_byp_first;
    bit e_tick, e_ack, e_err;

    function automatic void model_reset();
        m_n = DIV_RESET; m_left = 1; m_ph = 0; m_pend = 0;
        m_busy = 0; m_fresh = 1; m_byp_first = 0;
        e_tick = 0; e_ack = 0; e_err = 0;
    endfunction

    function automatic void model_edge(input bit req, input int val);
        bit busy_pre;
        int old_n;
        busy_pre = m_busy;
        e_tick = 0; e_ack = 0; e_err = 0;
        m_left--;
        if (m_left == 0) begin
            old_n = m_n;
            e_tick = 1;
            if (busy_pre) begin
                m_n = m_pend; m_busy = 0; e_ack = 1;
            end
            m_byp_first = (m_n == 1) && (m_fresh || old_n != 1);
            m_fresh = 0;
            m_left = m_n;
            m_ph = 0;
        end else begin
            m_ph++;
        end
        if (!busy_pre && req) begin
            if (val == 0) e_err = 1;
            else begin m_pend = val; m_busy = 1; end
        end
    endfunction

    // Number of high half-cycles at the start of each period
    function automatic bit exp_clk(input int half);
        int h;
        if (m_byp_first) return 1'b0;
        if (m_n == 1 || (m_n % 2) == 0 || ODD50) h = m_n;
        else h = m_n - 1;
        return (half < h);
    endfunction

    task automatic step(input bit req, input int val);
        bus.div_req = req;
        bus.div_val = DIV_W'(val);
        @(posedge clkin);
        model_edge(req, val);
        #1;
        check("tick",     32'(tick),         32'(e_tick));
        check("div_ack",  32'(bus.div_ack),  32'(e_ack));
        check("div_err",  32'(bus.div_err),  32'(e_err));
        check("div_busy", 32'(bus.div_busy), 32'(m_busy));
        check("cur_div",  32'(bus.cur_div),  32'(m_n));
        check("clk_hi_half", 32'(clk_out),   32'(exp_clk(2 * m_ph)));
        bus.div_req = 1'b0;
        @(negedge clkin);
        #1;
        check("clk_lo_half", 32'(clk_out),   32'(exp_clk(2 * m_ph + 1)));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #1;
        check("rst_clk_out", 32'(clk_out),      32'd0);
        check("rst_busy",    32'(bus.div_busy), 32'd0);
        check("rst_ack",     32'(bus.div_ack),  32'd0);
        check("rst_cur_div", 32'(bus.cur_div),  32'(DIV_RESET));
        @(negedge clkin);
        @(negedge clkin);
        #1;
        rstn = 1'b1;
        #1;
        check("rel_clk_out", 32'(clk_out), 32'd0);
    endtask

    initial begin
        bus.div_req = 1'b0;
        bus.div_val = '0;
        rstn = 1'b1;
        #2;
        do_reset();

        // Default divisor, then odd divisor requested mid-period
        run(6);
        step(1'b1, 3);
        run(10);

        // Into and out of bypass
        step(1'b1, 4);
        run(10);
        step(1'b1, 1);
        run(8);
        step(1'b1, 4);
        run(10);

        // Zero divisor error, then a second request while busy is ignored
        step(1'b1, 0);
        run(2);
        step(1'b1, 5);
        step(1'b1, 7);
        run(15);

        // Same-divisor request still acks; maximum divisor wraps cleanly
        step(1'b1, 5);
        run(8);
        step(1'b1, 15);
        run(40);

        // Reset while a change is pending at N=6
        step(1'b1, 6);
        run(14);
        for (int i = 0; i < 20 && m_ph != 1; i++) step(1'b0, 0);
        step(1'b1, 3);
        check("pend_before_rst", 32'(bus.div_busy), 32'd1);
        @(posedge clkin);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("midrst_clk_out", 32'(clk_out),      32'd0);
        check("midrst_busy",    32'(bus.div_busy), 32'd0);
        check("midrst_cur_div", 32'(bus.cur_div),  32'(DIV_RESET));
        @(negedge clkin);
        #1;
        rstn = 1'b1;
        run(10);

        // Random requests
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) step(1'b1, int'($urandom_range(0, 15)));
            else step(1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
